mult_seq: RTL and testbench
===========================

MULT_SEQ -- requirements
Module: mult_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand width in bits (legal 4..64).
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset, with ports as follows:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous abort.
- in_valid  input  1  operands offered.
- in_ready  output  1  block can accept operands.
- x  input  WIDTH  multiplicand.
- y  input  WIDTH  multiplier.
- sgn  input  1  1 = two's-complement operands; 0 = unsigned.
- out_valid  output  1  P holds a result.
- out_ready  input  1  consumer takes the result.
- P  output  2*WIDTH  product.
- busy  output  1  computation in progress.

Function
REQ-010 The block SHALL implement a 3-state FSM with states IDLE, BUSY and DONE.
REQ-011 In IDLE, in_ready SHALL be 1; it SHALL be 0 in all other states.
REQ-012 At a clock edge with in_valid=1 and in_ready=1 (acceptance edge T), the block SHALL:
- capture x, y and sgn;
- clear the accumulator;
- load the bit counter with WIDTH;
- enter BUSY.
REQ-013 In BUSY, each clock edge SHALL process one multiplier bit, LSB first, using shift-add: if the current multiplier bit is 1, the multiplicand is added into the upper accumulator half, then the accumulator is shifted right by 1 with the adder carry.
REQ-014 The counter SHALL decrement once per BUSY edge. On the edge where it reaches 0 (edge T+WIDTH), the final product SHALL be written to P, out_valid SHALL become 1 and the FSM SHALL enter DONE. Latency is therefore exactly WIDTH cycles from acceptance to out_valid.
REQ-015 busy SHALL be 1 exactly while in BUSY.
REQ-016 In DONE, P and out_valid SHALL hold stable until an edge with out_ready=1. At that edge out_valid SHALL go to 0 and the FSM SHALL return to IDLE. There is no same-edge accept in DONE.
REQ-017 Unsigned mode: P SHALL equal x*y exactly, as a 2*WIDTH-bit result with no truncation.
REQ-018 P SHALL retain the last result after handshake until the next result is written.
REQ-019 flush=1 at an edge SHALL force IDLE and out_valid=0 from any state, discarding any in-flight computation. flush SHALL take priority over acceptance and over out_ready.
REQ-020 A zero operand SHALL still take the full WIDTH cycles; there is no early termination.
REQ-021 Changes on x, y or sgn after the acceptance edge SHALL NOT affect the result.

Reset
REQ-030 While rst_n=0, the block SHALL immediately (asynchronously) set:
- state = IDLE;
- in_ready = 1, out_valid = 0, busy = 0;
- P = 0, accumulator = 0, counter = 0.
REQ-031 Reset assertion during BUSY or DONE SHALL discard the operation. No out_valid SHALL appear afterwards.
REQ-032 The first acceptance SHALL be possible on the first rising edge after rst_n deasserts.

Configuration
REQ-040 Signed support SHALL be controlled by the macro MULT_SEQ_SIGNED_EN.
REQ-041 With MULT_SEQ_SIGNED_EN defined and sgn=1 captured, operand magnitudes SHALL be taken at acceptance and the sign SHALL be XORed. The magnitude product SHALL be negated (two's complement) when written at edge T+WIDTH, so the latency is unchanged. P SHALL equal the signed product in 2*WIDTH bits, including (-2^(WIDTH-1))*(-2^(WIDTH-1)) = 2^(2*WIDTH-2).
REQ-042 Without MULT_SEQ_SIGNED_EN, the sgn port SHALL remain present but be ignored. All operations SHALL be unsigned, and no negation logic SHALL be synthesised.

Verification (WIDTH=16)
REQ-050 Max unsigned: x=0xFFFF, y=0xFFFF, sgn=0 -> out_valid rises 16 cycles after acceptance; P=0xFFFE0001.
REQ-051 Signed mixed (MULT_SEQ_SIGNED_EN): x=0xFFFD (-3), y=0x0005, sgn=1 -> P=0xFFFFFFF1. The same operands with sgn=0 -> P=0x0004FFF1.
REQ-052 Signed corner (MULT_SEQ_SIGNED_EN): x=0x8000, y=0x8000, sgn=1 -> P=0x40000000. Also x=0xFFFF, y=0xFFFF, sgn=1 -> P=0x00000001.
REQ-053 Back-pressure: out_ready=0 for 5 cycles after a result of x=0x1234, y=0x0010 -> P=0x00012340 held stable with out_valid=1 and in_ready=0. Releasing out_ready -> IDLE next edge; in_ready=1.
REQ-054 Abort: pulse rst_n low at cycle 7 of BUSY -> immediate out_valid=0, busy=0, P=0. Pulse flush at cycle 7 of another operation -> IDLE next edge; no result produced.
REQ-055 Back-to-back: in_valid held high with 3 operand pairs and out_ready=1 -> 3 correct results. Each acceptance occurs one edge after the previous handshake, with a spacing of WIDTH+2 cycles.

Source files
------------

// File: rtl/mult_seq.sv
// Sequential shift-add multiplier: one multiplier bit per clock, WIDTH cycles per product.
// Optional two's-complement support is enabled by defining MULT_SEQ_SIGNED_EN; without it
// the sgn input is accepted but ignored and every operation is unsigned.
module mult_seq #(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  input  logic               sgn,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] P,
  output logic               busy
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e             state_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] p_q;
  logic [CntW-1:0]    cnt_q;
  logic               out_valid_q;

  logic [WIDTH:0]     sum_d;
  logic [2*WIDTH-1:0] acc_d;
  logic [2*WIDTH-1:0] prod_d;
  logic [WIDTH-1:0]   mcand_in;
  logic [WIDTH-1:0]   mplier_in;

  // acc_q[0] is always shifted out; sgn is unused in the unsigned-only build
  logic unused_bits;
  assign unused_bits = ^{acc_q[0], sgn};

  // One shift-add step: add multiplicand into the upper half, then shift right with carry
  always_comb begin
    sum_d = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (mplier_q[0] ? mcand_q : '0)};
    acc_d = {sum_d, acc_q[WIDTH-1:1]};
  end

`ifdef MULT_SEQ_SIGNED_EN
  logic neg_q;
  logic neg_in;

  // Signed mode works on magnitudes; the result sign is the XOR of the operand signs
  always_comb begin
    mcand_in  = (sgn && x[WIDTH-1]) ? -x : x;
    mplier_in = (sgn && y[WIDTH-1]) ? -y : y;
    neg_in    = sgn & (x[WIDTH-1] ^ y[WIDTH-1]);
    prod_d    = neg_q ? -acc_d : acc_d;
  end
`else
  // Unsigned-only build: operands pass straight through, no negation
  always_comb begin
    mcand_in  = x;
    mplier_in = y;
    prod_d    = acc_d;
  end
`endif

  // Control FSM and datapath registers; flush outranks acceptance and the output handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      p_q         <= '0;
      out_valid_q <= 1'b0;
`ifdef MULT_SEQ_SIGNED_EN
      neg_q       <= 1'b0;
`endif
    end else if (flush) begin
      state_q     <= StIdle;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            mcand_q  <= mcand_in;
            mplier_q <= mplier_in;
            acc_q    <= '0;
            cnt_q    <= CntW'(WIDTH);
`ifdef MULT_SEQ_SIGNED_EN
            neg_q    <= neg_in;
`endif
            state_q  <= StBusy;
          end
        end
        StBusy: begin
          acc_q    <= acc_d;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q - CntW'(1);
          // Last bit: publish the product on the same edge the counter hits zero
          if (cnt_q == CntW'(1)) begin
            p_q         <= prod_d;
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q == StBusy);
  assign out_valid = out_valid_q;
  assign P         = p_q;

endmodule

// File: tb/tb_mult_seq.sv
// Self-checking bench for mult_seq (WIDTH=16): directed corners plus randomized operands
// compared against an arithmetic reference product. Honours MULT_SEQ_SIGNED_EN.
module tb_mult_seq;

  localparam int unsigned W = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           flush = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   x = '0;
  logic [W-1:0]   y = '0;
  logic           sgn = 1'b0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [2*W-1:0] P;
  logic           busy;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  logic [2*W-1:0] last_p = '0;

  mult_seq #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x        (x),
    .y        (y),
    .sgn      (sgn),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .P        (P),
    .busy     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference: the mathematical product, truncated to 2*W bits (exact for W=16)
  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic s);
    longint pa;
    longint pb;
    longint pr;
    logic   use_signed;
    use_signed = s;
`ifndef MULT_SEQ_SIGNED_EN
    use_signed = 1'b0;
`endif
    if (use_signed) begin
      pa = longint'($signed(a));
      pb = longint'($signed(b));
    end else begin
      pa = longint'(a);
      pb = longint'(b);
    end
    pr = pa * pb;
    return pr[2*W-1:0];
  endfunction

  // One full transaction with W-cycle latency checks, optional back-pressure, and handshake
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input int hold);
    logic [2*W-1:0] exp;
    exp = model(a, b, s);
    check("ready_idle", in_ready, 1);
    x = a; y = b; sgn = s; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    x = 16'($urandom); y = 16'($urandom); sgn = 1'($urandom);
    check("busy_start", busy, 1);
    repeat (W - 1) @(negedge clk);
    check("no_early_valid", out_valid, 0);
    check("busy_last", busy, 1);
    @(negedge clk);
    check("valid_at_W", out_valid, 1);
    check("busy_done", busy, 0);
    check("ready_done", in_ready, 0);
    check("product", P, exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_p", P, exp);
      check("hold_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("valid_clear", out_valid, 0);
    check("ready_back", in_ready, 1);
    check("p_retained", P, exp);
    out_ready = 1'b0;
    last_p = exp;
  endtask

  // Start an operation and abort it after seven BUSY edges by flush or by reset
  task automatic do_abort(input logic use_reset);
    logic seen;
    x = 16'h1357; y = 16'hBEEF; sgn = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    if (use_reset) begin
      #2 rst_n = 1'b0;
      #1;
      check("rst_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_p", P, 0);
      check("rst_ready", in_ready, 1);
      #1 rst_n = 1'b1;
      last_p = '0;
      @(negedge clk);
    end else begin
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush_ready", in_ready, 1);
      check("flush_busy", busy, 0);
      check("flush_valid", out_valid, 0);
    end
    seen = 1'b0;
    repeat (W + 4) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("abort_no_result", seen, 0);
    check("abort_p_kept", P, last_p);
  endtask

  // Three operand pairs with in_valid and out_ready held high
  task automatic do_b2b;
    logic [W-1:0]   xa [3];
    logic [W-1:0]   ya [3];
    logic           sa [3];
    logic [2*W-1:0] ex [3];
    int             ta [3];
    int             n;
    for (int i = 0; i < 3; i++) begin
      xa[i] = 16'($urandom); ya[i] = 16'($urandom); sa[i] = 1'($urandom);
      ex[i] = model(xa[i], ya[i], sa[i]);
    end
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      x = xa[i]; y = ya[i]; sgn = sa[i];
      n = 0;
      while (!in_ready && n < 100) begin
        @(negedge clk);
        n++;
      end
      check("b2b_ready", in_ready, 1);
      @(posedge clk);
      @(negedge clk);
      ta[i] = cyc;
      if (i == 2) in_valid = 1'b0;
      x = 16'($urandom); y = 16'($urandom);
      n = 0;
      while (!out_valid && n < 100) begin
        @(negedge clk);
        n++;
      end
      check("b2b_valid", out_valid, 1);
      check("b2b_p", P, ex[i]);
    end
    check("b2b_gap01", ta[1] - ta[0], W + 2);
    check("b2b_gap12", ta[2] - ta[1], W + 2);
    @(negedge clk);
    out_ready = 1'b0;
    last_p = ex[2];
  endtask

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;
    int sel;
    #3;
    check("reset_ready", in_ready, 1);
    check("reset_valid", out_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_p", P, 0);
    #7 rst_n = 1'b1;

    do_op(16'hFFFF, 16'hFFFF, 1'b0, 0);
    check("max_unsigned_const", P, 32'hFFFE0001);
    do_op(16'hFFFD, 16'h0005, 1'b0, 1);
    check("mixed_unsigned_const", P, 32'h0004FFF1);
    do_op(16'hFFFD, 16'h0005, 1'b1, 0);
    do_op(16'h8000, 16'h8000, 1'b1, 0);
    do_op(16'hFFFF, 16'hFFFF, 1'b1, 2);
    do_op(16'h1234, 16'h0010, 1'b0, 5);
    check("backpressure_const", P, 32'h00012340);
    do_op(16'h0000, 16'hABCD, 1'b0, 0);
    do_op(16'h7FFF, 16'h0000, 1'b1, 0);

    do_abort(1'b1);
    do_op(16'h00FF, 16'h0101, 1'b0, 0);
    do_abort(1'b0);
    do_b2b();

    for (int i = 0; i < 24; i++) begin
      sel = $urandom_range(0, 7);
      a = (sel == 0) ? 16'h0000 : (sel == 1) ? 16'h8000 : (sel == 2) ? 16'hFFFF
          : 16'($urandom);
      sel = $urandom_range(0, 7);
      b = (sel == 0) ? 16'h0000 : (sel == 1) ? 16'h8000 : (sel == 2) ? 16'hFFFF
          : 16'($urandom);
      do_op(a, b, 1'($urandom), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

endmodule
